// File: rtl/sram_pkg.sv
// Shared types and helpers for the masked single-port SRAM model.
// The SRAM_PARITY_EN build uses lane_parity for per-lane even parity.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Widest write lane the parity helper can take; narrower lanes are zero-extended.
  localparam int LANE_MAX = 64;

  function automatic logic lane_parity(input logic [LANE_MAX-1:0] data);
    return ^data;
  endfunction

  function automatic bit lanes_divide(input int data_width, input int write_size);
    return (write_size > 0) && (write_size <= LANE_MAX) && ((data_width % write_size) == 0);
  endfunction

endpackage

// File: rtl/sram_masked_array.sv
// Storage with lane-masked write and registered read; out-of-range writes drop, reads give 0.
// With SRAM_PARITY_EN an even-parity bit per lane is stored and checked on read.
module sram_masked_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WRITE_SIZE  = 8,
  parameter int WMASK_WIDTH = DATA_WIDTH / WRITE_SIZE,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  rdata
`ifdef SRAM_PARITY_EN
  ,
  output logic                   perr
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  in_range;

  assign in_range = ({1'b0, addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask[i]) begin
          mem[addr][i*WRITE_SIZE +: WRITE_SIZE] <= din[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  // The data register is reset so the response bus is never X before the first read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [WMASK_WIDTH-1:0] par [RAM_DEPTH];
  logic [WMASK_WIDTH-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask[i]) begin
          par[addr][i] <= lane_parity(LANE_MAX'(din[i*WRITE_SIZE +: WRITE_SIZE]));
        end
      end
    end
  end

  always_comb begin
    rd_par = '0;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      rd_par[i] = lane_parity(LANE_MAX'(mem[addr][i*WRITE_SIZE +: WRITE_SIZE]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (re) begin
      perr <= in_range ? |(rd_par ^ par[addr]) : 1'b0;
    end
  end
`endif

endmodule

// File: rtl/sram_sp_masked_init.sv
// Single-port SRAM with valid/ready requests, clear sweep after reset and optional output register.
// Optional feature macro: SRAM_PARITY_EN (adds per-lane parity and the parity_err output).
module sram_sp_masked_init
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WRITE_SIZE  = 8,
  parameter int WMASK_WIDTH = DATA_WIDTH / WRITE_SIZE,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int OUT_REG     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_dout,
  output logic                   init_done
`ifdef SRAM_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  // Handshake: a request transfers on every rising edge where req_valid && req_ready;
  // req_ready is a registered function of the FSM only and never looks at req_valid.

  if (!lanes_divide(DATA_WIDTH, WRITE_SIZE) || (WMASK_WIDTH != DATA_WIDTH / WRITE_SIZE) ||
      (RAM_DEPTH > (1 << ADDR_WIDTH)) || (RAM_DEPTH < 1)) begin : g_bad_cfg
    $error("sram_sp_masked_init: invalid geometry parameters");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_state_e            state;
  logic [ADDR_WIDTH-1:0]  cnt;
  logic                   accept;
  logic                   clearing;
  logic                   rd_v1;
  logic                   arr_we;
  logic                   arr_re;
  logic [WMASK_WIDTH-1:0] arr_wmask;
  logic [ADDR_WIDTH-1:0]  arr_addr;
  logic [DATA_WIDTH-1:0]  arr_din;
  logic [DATA_WIDTH-1:0]  rdata;
`ifdef SRAM_PARITY_EN
  logic                   rd_perr;
`endif

  assign accept   = req_valid && req_ready;
  assign clearing = (state == CLEAR);

  // The sweep owns the array port while clearing; requests cannot be accepted then.
  assign arr_we    = clearing || (accept && req_we);
  assign arr_re    = accept && !req_we;
  assign arr_wmask = clearing ? '1 : req_wmask;
  assign arr_addr  = clearing ? cnt : req_addr;
  assign arr_din   = clearing ? '0 : req_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state     <= READY;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        READY: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= arr_re;
    end
  end

  sram_masked_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WRITE_SIZE (WRITE_SIZE),
    .WMASK_WIDTH(WMASK_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .wmask(arr_wmask),
    .addr (arr_addr),
    .din  (arr_din),
    .rdata(rdata)
`ifdef SRAM_PARITY_EN
    ,
    .perr (rd_perr)
`endif
  );

  if (OUT_REG == 0) begin : g_direct
    assign rsp_valid = rd_v1;
    assign rsp_dout  = rdata;
`ifdef SRAM_PARITY_EN
    assign parity_err = rd_v1 & rd_perr;
`endif
  end else begin : g_oreg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_valid <= 1'b0;
        rsp_dout  <= '0;
      end else begin
        rsp_valid <= rd_v1;
        if (rd_v1) begin
          rsp_dout <= rdata;
        end
      end
    end
`ifdef SRAM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        parity_err <= 1'b0;
      end else begin
        parity_err <= rd_v1 & rd_perr;
      end
    end
`endif
  end

endmodule

// File: doc/sram_sp_masked_init.md
Name: sram_sp_masked_init

Overview:
- Parametrised single-port synchronous SRAM model; successor to the fixed 512x32 single-mask macro models.
- Adds a write mask per WRITE_SIZE lane, a valid/ready request handshake and a response-valid strobe.
- Adds an optional output register stage and a hardware clear sweep after reset, so contents are defined without simulation-only initialisation.
- Sits between the on-chip bus adapters and the SRAM macro slots; used for simulation and as a drop-in behavioural stand-in.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of WRITE_SIZE.
- ADDR_WIDTH, 9, address width.
- WRITE_SIZE, 8, bits per write-mask lane.
- WMASK_WIDTH, DATA_WIDTH/WRITE_SIZE, derived; must not be overridden.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 1<<ADDR_WIDTH.
- OUT_REG, 0, 0 = read latency 1 cycle, 1 = read latency 2 cycles.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  WMASK_WIDTH  per-lane write enable; ignored on reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_din  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid; single-cycle pulse per read.
- rsp_dout  out  DATA_WIDTH  read data.
- init_done  out  1  clear sweep finished.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_dout=0, init_done=0, FSM=CLEAR, clear counter=0, pipeline valids=0. Array contents are not touched by reset itself.
- FSM CLEAR:
  - Each cycle writes all-zero to mem[cnt], then increments cnt.
  - When cnt==RAM_DEPTH-1 is written, goes to READY on the next edge.
  - The sweep takes exactly RAM_DEPTH cycles after rst deasserts.
- FSM READY:
  - req_ready=1 and init_done=1.
  - Stays in READY until rst.
  - There is no other state.
- Accept rule: a transfer occurs on any edge where req_valid && req_ready. req_ready does not depend on req_valid. One request per cycle, with no bubbles.
- Write:
  - For each lane i with req_wmask[i]=1, mem[addr][i*WRITE_SIZE +: WRITE_SIZE] <= din lane; unmasked lanes keep their value.
  - wmask=0 is a legal no-op.
  - No rsp_valid pulse; rsp_dout holds its previous value (never X).
- Read latency:
  - OUT_REG=0: rsp_valid=1 and rsp_dout=mem[addr] on the edge after acceptance.
  - OUT_REG=1: data passes through one more register; valid and data appear 2 edges after acceptance.
- Write followed by read of the same address on the next cycle returns the newly written data; write-first ordering is guaranteed by sequential acceptance.
- rsp_dout holds its last read value while rsp_valid=0.
- Addresses >= RAM_DEPTH: writes are dropped, reads return 0 with a normal rsp_valid pulse.
- Reset mid-operation (including during CLEAR or with reads in flight):
  - In-flight reads are discarded with no rsp_valid.
  - The FSM restarts CLEAR from cnt=0.
- Requests presented while req_ready=0 are not accepted and must be held by the master.

Optional Feature:
- Macro SRAM_PARITY_EN.
- When defined:
  - The array stores one even-parity bit per lane, computed at write and cleared to 0 during CLEAR.
  - Adds output port parity_err (1 bit, reset 0), aligned with rsp_valid. It is 1 when any lane of the read word fails its check.
  - A partial write updates only the parity bits of written lanes.
- When undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package sram_pkg:
  - typedef enum sram_state_e {CLEAR, READY};
  - function lane_parity(data);
  - localparam checks for DATA_WIDTH % WRITE_SIZE == 0.
- Sub-module sram_masked_array:
  - Contains the storage, lane-masked write and synchronous read (plus parity bits under the macro).
- The top level holds the FSM, clear counter, handshake and output pipeline, and muxes clear writes into the array port.

Test Plan:
- Init sweep (RAM_DEPTH=512, OUT_REG=0): deassert rst → req_ready and init_done rise exactly 512 cycles later. A read of addr 0x1FF then returns 0x00000000 with rsp_valid one cycle after acceptance.
- Masked write: write 0xDEADBEEF wmask=4'b1111 to 0x010, then 0x00001234 wmask=4'b0001 → a read of 0x010 returns 0xDEADBE34.
- Back-to-back with OUT_REG=1: write 0xA5A5A5A5 to 0x003, then read 0x003 on the next cycle, then read 0x004 → rsp_valid pulses 2 cycles after each read acceptance, with data 0xA5A5A5A5 then 0x00000000, in consecutive cycles.
- Reset mid-flight: accept a read of 0x010 and assert rst the next cycle → no rsp_valid pulse, req_ready=0, and the sweep restarts. After the sweep, a read of 0x010 returns 0.
- Out-of-range (RAM_DEPTH=300, ADDR_WIDTH=9): write 0xFFFFFFFF to 0x150, then read 0x150 → rsp_valid=1 and data 0. A read of 0x12B returns 0 after the sweep completes in exactly 300 cycles.
- SRAM_PARITY_EN: force-flip one stored bit in lane 2 of 0x020 and read it → parity_err=1 coincident with rsp_valid. Rewrite lane 2 only and read again → parity_err=0.
